// File: rtl/mul_sequencer.sv
// Sequential shift-add multiplier: one adder step per cycle for WIDTH cycles,
// then a sign-fix cycle that writes the registered hi/lo product.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand_mag;
  logic [2*WIDTH-1:0] prod;
  logic               neg;
  logic               accept;
  logic [WIDTH:0]     step_sum;

  // Magnitude of an operand; the most negative value maps onto 2^(WIDTH-1)
  // as an unsigned number, which the unsigned datapath handles without loss.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    is_signed);
    logic [WIDTH-1:0] r;
    r = v;
    if (is_signed && v[WIDTH-1]) begin
      r = ~v + 1'b1;
    end
    return r;
  endfunction

  // Restores the sign of the unsigned product by two's-complement negation.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic               make_neg);
    logic [2*WIDTH-1:0] r;
    r = p;
    if (make_neg) begin
      r = ~p + 1'b1;
    end
    return r;
  endfunction

  assign accept = start && ((state == IDLE) || (state == DONE));

  // Single WIDTH-bit adder: adds |A| to the upper half when the current
  // multiplier bit (P[0]) is set; bit WIDTH is the carry C.
  always_comb begin
    step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand_mag : '0)};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; cancel only matters while an operation is in flight,
  // so cancel with start in DONE behaves like start alone.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = CALC;
      end
      CALC: begin
        if (cancel)                  state_nxt = IDLE;
        else if (cnt == LAST_STEP)   state_nxt = FIX;
      end
      FIX: begin
        if (cancel) state_nxt = IDLE;
        else        state_nxt = DONE;
      end
      DONE: begin
        if (start) state_nxt = CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs: operand load on accept, one shift-add
  // step per CALC cycle, result written only on an uncancelled FIX edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      mcand_mag <= '0;
      prod      <= '0;
      neg       <= 1'b0;
    end else begin
      busy <= (state_nxt == CALC) || (state_nxt == FIX);
      done <= (state_nxt == DONE);

      if (accept) begin
        mcand_mag <= magnitude(multiplicand, signed_op);
        prod      <= {{WIDTH{1'b0}}, magnitude(multiplier, signed_op)};
        neg       <= signed_op && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        cnt       <= '0;
      end else if ((state == CALC) && !cancel) begin
        prod <= {step_sum, prod[WIDTH-1:1]};
        cnt  <= cnt + 1'b1;
      end

      if ((state == FIX) && !cancel) begin
        {hi, lo} <= apply_sign(prod, neg);
      end
    end
  end

endmodule
